// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches the output of a one-hot ring counter. The pattern is registered
//   twice (q_r, q_p), and each cycle the monitor checks that q_r is one-hot and
//   that it either advanced one position in direction DIR or held still. After
//   LOCK_CNT consecutive advances it declares lock. It then reports the binary
//   phase index, counts full revolutions and flags pattern faults.
//
// Parameters
//   WIDTH    ring width in bits (>= 2)
//   DIR      expected rotation: 0 = toward MSB, 1 = toward LSB
//   LOCK_CNT consecutive valid steps needed to lock (1..15)
//   REV_W    revolution counter width
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   q_in       ring counter output being monitored
//   err_clr    synchronous clear of err_sticky (a simultaneous fault wins)
//   idx        binary position of the hot bit (holds while q_r is not one-hot)
//   idx_valid  idx is meaningful (locked and one-hot)
//   locked     monitor is in the LOCKED state
//   err        one-cycle pulse on a fault while locked
//   err_sticky latched fault flag
//   rev_tick   one-cycle pulse per completed revolution while locked
//   rev_cnt    revolutions since reset, wraps modulo 2**REV_W
module ring_phase_monitor #(
  parameter int WIDTH    = 4,
  parameter bit DIR      = 1'b0,
  parameter int LOCK_CNT = 4,
  parameter int REV_W    = 8,
  localparam int IW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] q_in,
  input  logic             err_clr,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             err,
  output logic             err_sticky,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_cnt
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       run;
  logic [3:0]       run_nxt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_p;
  logic [WIDTH-1:0] nxt;
  logic [IW-1:0]    enc;
  logic             onehot;
  logic             step_ok;
  logic             hold_ok;
  logic             bad;
  logic             err_set;
  logic             tick;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign onehot = (q_r != '0) && ((q_r & (q_r - WIDTH'(1))) == '0);

  // Where the previous pattern should have moved to.
  always_comb begin
    if (DIR) nxt = {q_p[0], q_p[WIDTH-1:1]};
    else     nxt = {q_p[WIDTH-2:0], q_p[WIDTH-1]};
  end

  // With q_p = 0 (first sample after reset) nxt is 0, so step_ok cannot hold.
  assign step_ok = onehot && (q_r == nxt);
  assign hold_ok = onehot && (q_r == q_p);
  assign bad     = !step_ok && !hold_ok;

  // Priority encoder; only consumed when q_r is one-hot.
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_r[i]) enc = IW'(i);
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    err_set   = 1'b0;
    tick      = 1'b0;
    unique case (state)
      SEARCH: begin
        if (step_ok) begin
          if (run == 4'(LOCK_CNT - 1)) begin
            state_nxt = LOCKED;
            run_nxt   = '0;
          end else begin
            run_nxt = run + 4'd1;
          end
        end else if (bad) begin
          run_nxt = '0;
        end
      end
      LOCKED: begin
        if (bad) begin
          state_nxt = SEARCH;
          run_nxt   = '0;
          err_set   = 1'b1;
        end else if (step_ok && q_r[0]) begin
          // Only counted while already locked, so the locking step never ticks.
          tick = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_r        <= '0;
      q_p        <= '0;
      state      <= SEARCH;
      run        <= '0;
      idx        <= '0;
      idx_valid  <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      rev_tick   <= 1'b0;
      rev_cnt    <= '0;
    end else begin
      q_r       <= q_in;
      q_p       <= q_r;
      state     <= state_nxt;
      run       <= run_nxt;
      locked    <= (state_nxt == LOCKED);
      idx_valid <= onehot && (state_nxt == LOCKED);
      err       <= err_set;
      rev_tick  <= tick;
      if (onehot) idx <= enc;
      if (tick)   rev_cnt <= rev_cnt + REV_W'(1);
      // A new fault takes priority over a simultaneous clear request.
      if (err_set)      err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor
//   Directed bench for ring_phase_monitor (WIDTH=4, DIR=0, LOCK_CNT=4). A second
//   instance with REV_W=2 shares the stimulus to exercise rev_cnt wrap-around.
//   Inputs change 1 ns after a rising edge; outputs are read at the same point,
//   so each read reflects the most recent edge.
module tb_ring_phase_monitor;

  logic       clk;
  logic       clr;
  logic [3:0] q_in;
  logic       err_clr;

  logic [1:0] idx;
  logic       idx_valid;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic       rev_tick;
  logic [7:0] rev_cnt;

  logic [1:0] idx_s;
  logic       idx_valid_s;
  logic       locked_s;
  logic       err_s;
  logic       err_sticky_s;
  logic       rev_tick_s;
  logic [1:0] rev_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int ticks;

  ring_phase_monitor dut (
    .clk        (clk),
    .clr        (clr),
    .q_in       (q_in),
    .err_clr    (err_clr),
    .idx        (idx),
    .idx_valid  (idx_valid),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .rev_tick   (rev_tick),
    .rev_cnt    (rev_cnt)
  );

  ring_phase_monitor #(.REV_W(2)) dut_w2 (
    .clk        (clk),
    .clr        (clr),
    .q_in       (q_in),
    .err_clr    (err_clr),
    .idx        (idx_s),
    .idx_valid  (idx_valid_s),
    .locked     (locked_s),
    .err        (err_s),
    .err_sticky (err_sticky_s),
    .rev_tick   (rev_tick_s),
    .rev_cnt    (rev_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one input vector, then advance to 1 ns after the next rising edge.
  task automatic step(input logic [3:0] v, input logic ec);
    q_in    = v;
    err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  // Drive the next clean ring position (toward MSB).
  task automatic ring_step();
    logic [3:0] v;
    v   = 4'b0001 << pos;
    pos = (pos + 1) % 4;
    step(v, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_idx"},        idx,          0);
    check({tag, "_idx_valid"},  idx_valid,    0);
    check({tag, "_locked"},     locked,       0);
    check({tag, "_err"},        err,          0);
    check({tag, "_err_sticky"}, err_sticky,   0);
    check({tag, "_rev_tick"},   rev_tick,     0);
    check({tag, "_rev_cnt"},    rev_cnt,      0);
    check({tag, "_s_idx"},      idx_s,        0);
    check({tag, "_s_valid"},    idx_valid_s,  0);
    check({tag, "_s_locked"},   locked_s,     0);
    check({tag, "_s_err"},      err_s,        0);
    check({tag, "_s_sticky"},   err_sticky_s, 0);
    check({tag, "_s_tick"},     rev_tick_s,   0);
    check({tag, "_s_rev_cnt"},  rev_cnt_s,    0);
  endtask

  // From reset with 0001 sampled at edge 1: the first compare (q_p=0) is bad,
  // steps land on edges 3..6, lock shows after edge 6 with q_r=0001 but no
  // tick; the first revolution tick follows after edge 10.
  task automatic lock_seq(input string tag);
    for (int k = 1; k <= 10; k++) begin
      ring_step();
      check({tag, "_idx"},       idx,       (k < 2) ? 0 : (k - 2) % 4);
      check({tag, "_locked"},    locked,    (k >= 6) ? 1 : 0);
      check({tag, "_idx_valid"}, idx_valid, (k >= 6) ? 1 : 0);
      check({tag, "_err"},       err,       0);
      check({tag, "_rev_tick"},  rev_tick,  (k == 10) ? 1 : 0);
    end
    check({tag, "_rev_cnt"}, rev_cnt, 1);
  endtask

  initial begin
    clr     = 1'b0;
    q_in    = 4'b0000;
    err_clr = 1'b0;
    #12;
    check_zero("reset");
    clr = 1'b1;

    // 1: clean rotation from reset to lock (edges 1..10).
    pos = 0;
    lock_seq("lock");

    // 2: hold at 0100 for three samples (edges 11..13), then resume.
    for (int k = 11; k <= 13; k++) begin
      step(4'b0100, 1'b0);
      check("hold_locked", locked, 1);
      check("hold_err", err, 0);
      check("hold_tick", rev_tick, 0);
      if (k > 11) check("hold_idx", idx, 2);
    end
    pos = 3;
    ring_step();                      // edge 14 samples 1000, q_r still held
    check("hold_idx_last", idx, 2);
    check("hold_locked_last", locked, 1);
    ring_step();                      // edge 15 samples 0001
    check("resume_idx", idx, 3);

    // 3: single multi-hot sample while locked.
    step(4'b0110, 1'b0);              // edge 16: q_r=0001 completes a revolution
    check("pre_fault_tick", rev_tick, 1);
    check("pre_fault_rev_cnt", rev_cnt, 2);
    pos = 1;
    ring_step();                      // edge 17: q_r=0110 is bad
    check("fault_err", err, 1);
    check("fault_sticky", err_sticky, 1);
    check("fault_locked", locked, 0);
    check("fault_idx_valid", idx_valid, 0);
    check("fault_idx_hold", idx, 0);
    check("fault_rev_cnt", rev_cnt, 2);
    ring_step();                      // edge 18: q_r=0010 after 0110, still bad
    check("fault_err_pulse", err, 0);
    check("fault_sticky_keep", err_sticky, 1);
    check("fault_idx_new", idx, 1);
    for (int k = 19; k <= 21; k++) begin
      ring_step();
      check("relock_wait", locked, 0);
    end
    ring_step();                      // edge 22: fourth valid step
    check("relock", locked, 1);
    check("relock_valid", idx_valid, 1);

    // 4: three full rotations while locked (edges 23..34).
    ticks = 0;
    for (int k = 23; k <= 34; k++) begin
      ring_step();
      check("rot_locked", locked, 1);
      if (rev_tick) begin
        ticks++;
        check("rot_tick_idx", idx, 0);
      end
    end
    check("rot_ticks", ticks, 3);
    check("rot_rev_cnt", rev_cnt, 5);
    check("rot_rev_cnt_w2", rev_cnt_s, 1);

    // 5: clear and new fault on the same edge; then clear alone.
    step(4'b0000, 1'b0);              // edge 35 samples an all-zero pattern
    check("zero_pre_locked", locked, 1);
    step(4'b0001, 1'b1);              // edge 36: fault and err_clr together
    check("clr_vs_set_err", err, 1);
    check("clr_vs_set_sticky", err_sticky, 1);
    check("clr_vs_set_locked", locked, 0);
    step(4'b0010, 1'b1);              // edge 37: err_clr alone
    check("clr_alone_sticky", err_sticky, 0);
    check("clr_alone_err", err, 0);
    err_clr = 1'b0;

    // Relock; the locking step has q_r=0001 and must not tick (edges 38..41).
    pos = 2;
    for (int k = 38; k <= 40; k++) begin
      ring_step();
      check("relock2_wait", locked, 0);
    end
    ring_step();
    check("relock2", locked, 1);
    check("relock2_idx", idx, 0);
    check("relock2_no_tick", rev_tick, 0);
    check("relock2_rev_cnt", rev_cnt, 5);

    // 6: asynchronous reset between edges while locked.
    #2;
    clr = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    clr = 1'b1;
    pos = 0;
    lock_seq("after_reset");
    check("after_reset_rev_cnt_w2", rev_cnt_s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
